// File: rtl/ehl_ahb_lite_master_if.sv
// Command/response stream and AHB-Lite bus signals for ehl_ahb_lite_master.
// The master modport is the initiator side; the slave modport is seen by the
// command source and the AHB slave.
interface ehl_ahb_lite_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [7:0]    err_cnt;

  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic          hready;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_err, rsp_rdata, busy, err_cnt,
    output haddr, htrans, hwrite, hsize, hwdata, hburst, hprot,
    input  hready, hresp, hrdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_err, rsp_rdata, busy, err_cnt,
    input  haddr, htrans, hwrite, hsize, hwdata, hburst, hprot,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ehl_ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined SINGLE
// NONSEQ transfers, with wait-state support and two-cycle ERROR cancel/reissue.
module ehl_ahb_lite_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  ehl_ahb_lite_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic          ap_valid;
  logic          ap_hold;
  logic          ap_write;
  logic [AW-1:0] ap_addr;
  logic [2:0]    ap_size;
  logic [DW-1:0] ap_wdata;

  logic          dp_valid;
  logic          dp_write;
  logic [DW-1:0] dp_wdata;

  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;
  logic [7:0]    err_cnt_q;

  logic          ap_issue;
  logic          dp_error;
  logic          cmd_ready_c;
  logic          cmd_accept;
  logic          unused_hresp1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    ap_issue    = ap_valid & ~ap_hold;
    dp_error    = dp_valid & bus.hresp[0];
    cmd_ready_c = (~ap_valid | bus.hready) & ~ap_hold & ~dp_error;
    cmd_accept  = bus.cmd_valid & cmd_ready_c;
  end

  // Address phase -> data phase -> response; everything advances only on hready
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ap_valid    <= 1'b0;
      ap_hold     <= 1'b0;
      ap_write    <= 1'b0;
      ap_addr     <= '0;
      ap_size     <= 3'b010;
      ap_wdata    <= '0;
      dp_valid    <= 1'b0;
      dp_write    <= 1'b0;
      dp_wdata    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (bus.hready) begin
        if (dp_valid) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= bus.hresp[0];
          rsp_rdata_q <= (!dp_write && !bus.hresp[0]) ? bus.hrdata : '0;
          if (bus.hresp[0]) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
          end
        end
        dp_valid <= ap_issue;
        if (ap_issue) begin
          dp_write <= ap_write;
          dp_wdata <= ap_wdata;
        end
        // A held address survives the second ERROR cycle and is reissued next
        ap_hold <= 1'b0;
        if (cmd_accept) begin
          ap_valid <= 1'b1;
          ap_addr  <= bus.cmd_addr;
          ap_write <= bus.cmd_write;
          ap_size  <= bus.cmd_size;
          ap_wdata <= bus.cmd_wdata;
        end else if (ap_issue) begin
          ap_valid <= 1'b0;
        end
      end else if (dp_error && ap_valid) begin
        ap_hold <= 1'b1;
      end
    end
  end

  assign unused_hresp1 = bus.hresp[1];

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.htrans    = ap_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr     = ap_addr;
  assign bus.hwrite    = ap_write;
  assign bus.hsize     = ap_size;
  assign bus.hwdata    = dp_wdata;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = 4'b0011;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = ap_valid | dp_valid;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ehl_ahb_lite_master.sv
// Directed bench for ehl_ahb_lite_master with a reactive AHB slave model and a
// response scoreboard filled at command acceptance.
module tb_ehl_ahb_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic hclk;
  logic hresetn;

  ehl_ahb_lite_master_if #(.AW(AW), .DW(DW)) bus ();

  ehl_ahb_lite_master #(.AW(AW), .DW(DW)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // Slave configuration
  int            cfg_delay   = 0;
  logic          cfg_err_all = 1'b0;
  logic          cfg_err_en  = 1'b0;
  logic [AW-1:0] cfg_err_addr = '0;

  int rsp_cnt = 0;
  int ns_run = 0, ns_max = 0, rsp_run = 0, rsp_max = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return {8'hDE, a[23:0]};
  endfunction

  function automatic logic model_err(input logic [AW-1:0] a);
    return cfg_err_all || (cfg_err_en && (a == cfg_err_addr));
  endfunction

  // AHB slave model: programmable wait states, two-cycle ERROR
  int            s_state;
  int            s_rem;
  logic [AW-1:0] s_addr;
  logic          s_write;
  logic          s_err;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      bus.hready <= 1'b1;
      bus.hresp  <= 2'b00;
      bus.hrdata <= '0;
      s_state    <= 0;
      s_rem      <= 0;
    end else if (bus.hready) begin
      if (bus.htrans == 2'b10) begin
        s_addr  <= bus.haddr;
        s_write <= bus.hwrite;
        s_err   <= model_err(bus.haddr);
        if (cfg_delay > 0) begin
          bus.hready <= 1'b0;
          bus.hresp  <= 2'b00;
          bus.hrdata <= '0;
          s_rem      <= cfg_delay - 1;
          s_state    <= 1;
        end else if (model_err(bus.haddr)) begin
          bus.hready <= 1'b0;
          bus.hresp  <= 2'b01;
          bus.hrdata <= '0;
          s_state    <= 2;
        end else begin
          bus.hready <= 1'b1;
          bus.hresp  <= 2'b00;
          bus.hrdata <= bus.hwrite ? '0 : rd_val(bus.haddr);
          s_state    <= 0;
        end
      end else begin
        bus.hready <= 1'b1;
        bus.hresp  <= 2'b00;
        bus.hrdata <= '0;
        s_state    <= 0;
      end
    end else if (s_state == 1) begin
      if (s_rem > 0) begin
        s_rem <= s_rem - 1;
      end else if (s_err) begin
        bus.hresp <= 2'b01;
        s_state   <= 2;
      end else begin
        bus.hready <= 1'b1;
        bus.hrdata <= s_write ? '0 : rd_val(s_addr);
        s_state    <= 0;
      end
    end else if (s_state == 2) begin
      bus.hready <= 1'b1;
      bus.hresp  <= 2'b01;
      s_state    <= 0;
    end
  end

  // Response monitor and scoreboard compare
  always @(negedge hclk) begin
    if (hresetn) begin
      if (bus.htrans == 2'b10) ns_run++; else ns_run = 0;
      if (ns_run > ns_max) ns_max = ns_run;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        rsp_run++;
        if (rsp_run > rsp_max) rsp_max = rsp_run;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        end
      end else begin
        rsp_run = 0;
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic w, input logic [2:0] sz,
                          input logic [DW-1:0] wd);
    int n;
    exp_t e;
    @(negedge hclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_size  = sz;
    bus.cmd_wdata = wd;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge hclk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_accept_timeout", 64'(bus.cmd_ready), 64'(1));
      bus.cmd_valid = 1'b0;
    end else begin
      e.err   = model_err(a);
      e.rdata = (!w && !e.err) ? rd_val(a) : '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    @(negedge hclk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge hclk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    hresetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 3'b010;
    bus.cmd_wdata = '0;
    repeat (3) @(negedge hclk);
    chk("rst_htrans", 64'(bus.htrans), 64'(2'b00));
    chk("rst_hsize", 64'(bus.hsize), 64'(3'b010));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_err_cnt", 64'(bus.err_cnt), 64'(0));
    chk("hburst", 64'(bus.hburst), 64'(3'b000));
    chk("hprot", 64'(bus.hprot), 64'(4'b0011));
    hresetn = 1'b1;

    // 1: single zero-wait write, latency check
    send_cmd(32'h100, 1'b1, 3'b010, 32'hCAFEF00D);
    @(negedge hclk);
    bus.cmd_valid = 1'b0;
    chk("t1_htrans_nonseq", 64'(bus.htrans), 64'(2'b10));
    chk("t1_haddr", 64'(bus.haddr), 64'(32'h100));
    chk("t1_hwrite", 64'(bus.hwrite), 64'(1));
    @(negedge hclk);
    chk("t1_hwdata", 64'(bus.hwdata), 64'(32'hCAFEF00D));
    chk("t1_htrans_idle", 64'(bus.htrans), 64'(2'b00));
    @(negedge hclk);
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    wait_idle();

    // 2: reads with 3 wait states; second read stalls in address phase
    cfg_delay = 3;
    send_cmd(32'h2, 1'b0, 3'b000, '0);
    send_cmd(32'h6, 1'b0, 3'b000, '0);
    @(negedge hclk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hready_low", 64'(bus.hready), 64'(0));
      chk("t2_cmd_ready_low", 64'(bus.cmd_ready), 64'(0));
      chk("t2_haddr_stable", 64'(bus.haddr), 64'(32'h6));
      chk("t2_htrans_stable", 64'(bus.htrans), 64'(2'b10));
      @(negedge hclk);
    end
    chk("t2_hready_back", 64'(bus.hready), 64'(1));
    wait_idle();
    cfg_delay = 0;

    // 3: four back-to-back zero-wait reads
    ns_max = 0;
    rsp_max = 0;
    for (int i = 0; i < 4; i++) send_cmd(32'(i * 4), 1'b0, 3'b010, '0);
    wait_idle();
    chk("t3_nonseq_run", 64'(ns_max), 64'(4));
    chk("t3_rsp_run", 64'(rsp_max), 64'(4));

    // 4: ERROR on A with B pipelined behind it
    cfg_err_en   = 1'b1;
    cfg_err_addr = 32'h40;
    send_cmd(32'h40, 1'b0, 3'b010, '0);
    send_cmd(32'h44, 1'b0, 3'b010, '0);
    @(negedge hclk);
    bus.cmd_valid = 1'b0;
    chk("t4_err1_hready", 64'(bus.hready), 64'(0));
    chk("t4_err1_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    @(negedge hclk);
    chk("t4_err2_htrans_idle", 64'(bus.htrans), 64'(2'b00));
    chk("t4_err2_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    @(negedge hclk);
    chk("t4_rsp_err_valid", 64'(bus.rsp_valid), 64'(1));
    chk("t4_reissue_htrans", 64'(bus.htrans), 64'(2'b10));
    chk("t4_reissue_haddr", 64'(bus.haddr), 64'(32'h44));
    wait_idle();
    chk("t4_err_cnt", 64'(bus.err_cnt), 64'(1));
    cfg_err_en = 1'b0;

    // 5: asynchronous reset in the middle of a wait state
    cfg_delay = 5;
    send_cmd(32'h80, 1'b0, 3'b010, 32'h12345678);
    @(negedge hclk);
    bus.cmd_valid = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    chk("t5_in_wait", 64'(bus.hready), 64'(0));
    #2 hresetn = 1'b0;
    #1;
    chk("t5_htrans", 64'(bus.htrans), 64'(2'b00));
    chk("t5_haddr", 64'(bus.haddr), 64'(0));
    chk("t5_hwrite", 64'(bus.hwrite), 64'(0));
    chk("t5_hsize", 64'(bus.hsize), 64'(3'b010));
    chk("t5_hwdata", 64'(bus.hwdata), 64'(0));
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t5_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("t5_busy", 64'(bus.busy), 64'(0));
    chk("t5_err_cnt", 64'(bus.err_cnt), 64'(0));
    exp_q.delete();
    cfg_delay = 0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    r0 = rsp_cnt;
    repeat (10) @(negedge hclk);
    chk("t5_no_rsp_after", 64'(rsp_cnt), 64'(r0));
    chk("t5_idle_after", 64'(bus.busy), 64'(0));

    // 6: err_cnt saturation
    cfg_err_all = 1'b1;
    for (int i = 0; i < 255; i++) send_cmd(32'h200 + 32'(i * 4), 1'(i % 2), 3'b010, 32'(i));
    wait_idle();
    chk("t6_err_cnt_255", 64'(bus.err_cnt), 64'(255));
    for (int i = 0; i < 5; i++) send_cmd(32'h600 + 32'(i * 4), 1'b0, 3'b010, '0);
    wait_idle();
    chk("t6_err_cnt_sat", 64'(bus.err_cnt), 64'(255));
    cfg_err_all = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
